// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// The result is computed when the op is accepted and is committed after a countdown that models the latency.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mul_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mt_en,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  input  logic [1:0]       mf_sel,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   pend_hi, pend_lo;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               is_signed, neg_a, neg_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_u, rem_u, quo, rem;

  assign is_signed = mul_op[0];

  // Signed multiply: sign-extend both operands to 2*WIDTH, then keep the low 2*WIDTH product bits.
  assign ext_a = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign ext_b = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign prod  = ext_a * ext_b;

  // Signed divide runs on magnitudes. MIN / -1 then yields quotient MIN and remainder 0.
  assign neg_a = is_signed & src_a[WIDTH-1];
  assign neg_b = is_signed & src_b[WIDTH-1];
  assign mag_a = neg_a ? -src_a : src_a;
  assign mag_b = neg_b ? -src_b : src_b;
  assign quo_u = mag_a / mag_b;
  assign rem_u = mag_a % mag_b;
  assign quo   = (neg_a ^ neg_b) ? -quo_u : quo_u;
  assign rem   = neg_a ? -rem_u : rem_u;

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (mul_op[1]) begin
      if (src_b == '0) begin
        res_hi = src_a;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  assign busy  = (cnt != '0);
  assign stall = busy & (start | mt_en | (mf_sel != 2'b00));

  always_comb begin
    case (mf_sel)
      2'b01:   rd_data = lo;
      2'b10:   rd_data = hi;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (cancel) begin
      // A flush kills whatever sits in EX, including a same-cycle start or MT.
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      cnt     <= mul_op[1] ? DIV_LD : MUL_LD;
    end else if (mt_en) begin
      if (mt_sel) hi <= mt_data;
      else        lo <= mt_data;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit. Instance 0 uses the 32-bit/5/10 configuration and instance 1 uses 16-bit/1/3.
// Expected HI/LO values are queued at launch and popped when busy drops.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start[2], mt_en[2], mt_sel[2], cancel[2];
  logic [1:0]  mul_op[2], mf_sel[2];
  logic [31:0] src_a[2], src_b[2], mt_data[2];
  logic        busy_w[2], stall_w[2];
  logic [31:0] hi_w[2], lo_w[2], rd_w[2];
  logic [31:0] hi32, lo32, rd32;
  logic [15:0] hi16, lo16, rd16;

  muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u32 (
    .clk(clk), .reset(reset), .start(start[0]), .mul_op(mul_op[0]),
    .src_a(src_a[0]), .src_b(src_b[0]), .mt_en(mt_en[0]), .mt_sel(mt_sel[0]),
    .mt_data(mt_data[0]), .mf_sel(mf_sel[0]), .cancel(cancel[0]),
    .busy(busy_w[0]), .stall(stall_w[0]), .rd_data(rd32), .hi(hi32), .lo(lo32));

  muldiv_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u16 (
    .clk(clk), .reset(reset), .start(start[1]), .mul_op(mul_op[1]),
    .src_a(src_a[1][15:0]), .src_b(src_b[1][15:0]), .mt_en(mt_en[1]), .mt_sel(mt_sel[1]),
    .mt_data(mt_data[1][15:0]), .mf_sel(mf_sel[1]), .cancel(cancel[1]),
    .busy(busy_w[1]), .stall(stall_w[1]), .rd_data(rd16), .hi(hi16), .lo(lo16));

  assign hi_w[0] = hi32;
  assign lo_w[0] = lo32;
  assign rd_w[0] = rd32;
  assign hi_w[1] = {16'h0, hi16};
  assign lo_w[1] = {16'h0, lo16};
  assign rd_w[1] = {16'h0, rd16};

  int n_cmp = 0;
  int n_err = 0;
  int mul_n[2] = '{5, 1};
  int div_n[2] = '{10, 3};
  int wid[2]   = '{32, 16};
  logic [31:0] cur_hi[2], cur_lo[2];
  logic [63:0] q0[$], q1[$];

  typedef struct {
    int          d;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    bit          probe;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint unsigned mask, ua, ub, p, h, l;
    longint sa, sb, sp;
    mask = (64'd1 << w) - 1;
    ua = a & mask;
    ub = b & mask;
    sa = ua;
    sb = ub;
    if (ua[w-1]) sa = sa - (64'sd1 <<< w);
    if (ub[w-1]) sb = sb - (64'sd1 <<< w);
    h = 0;
    l = 0;
    case (op)
      2'b00: begin p = ua * ub; h = (p >> w) & mask; l = p & mask; end
      2'b01: begin sp = sa * sb; p = sp; h = (p >> w) & mask; l = p & mask; end
      default: begin
        if (ub == 0) begin
          h = ua;
          l = mask;
        end else if (op == 2'b10) begin
          h = ua % ub;
          l = ua / ub;
        end else begin
          sp = sa % sb; h = sp; h = h & mask;
          sp = sa / sb; l = sp; l = l & mask;
        end
      end
    endcase
    return {h[31:0], l[31:0]};
  endfunction

  task automatic run_op(int d, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp, bit probe);
    int n, cnt;
    logic [63:0] got;
    @(negedge clk);
    start[d] = 1'b1; mul_op[d] = op; src_a[d] = a; src_b[d] = b;
    if (d == 0) q0.push_back(exp); else q1.push_back(exp);
    @(negedge clk);
    start[d] = 1'b0;
    n = op[1] ? div_n[d] : mul_n[d];
    cnt = 0;
    while (busy_w[d] && cnt < 100) begin
      cnt++;
      if (probe && cnt == 1) begin
        mf_sel[d] = 2'b01; #1;
        chk("mflo_busy_stall", 32'(stall_w[d]), 32'd1);
        chk("mflo_busy_old_lo", rd_w[d], cur_lo[d]);
        mf_sel[d] = 2'b10; #1;
        chk("mfhi_busy_old_hi", rd_w[d], cur_hi[d]);
        mf_sel[d] = 2'b00;
        start[d] = 1'b1; mt_en[d] = 1'b1; mt_sel[d] = 1'b0; mt_data[d] = 32'h0000DEAD; #1;
        chk("start_mt_busy_stall", 32'(stall_w[d]), 32'd1);
      end
      @(negedge clk);
      start[d] = 1'b0;
      mt_en[d] = 1'b0;
    end
    chk("latency", 32'(cnt), 32'(n));
    if (d == 0) got = (q0.size() > 0) ? q0.pop_front() : 64'hx;
    else        got = (q1.size() > 0) ? q1.pop_front() : 64'hx;
    chk("result_hi", hi_w[d], got[63:32]);
    chk("result_lo", lo_w[d], got[31:0]);
    cur_hi[d] = got[63:32];
    cur_lo[d] = got[31:0];
  endtask

  task automatic mt_write(int d, logic sel, logic [31:0] data);
    @(negedge clk);
    mt_en[d] = 1'b1; mt_sel[d] = sel; mt_data[d] = data; #1;
    chk("mt_idle_stall", 32'(stall_w[d]), 32'd0);
    @(negedge clk);
    mt_en[d] = 1'b0;
    if (sel) cur_hi[d] = data; else cur_lo[d] = data;
    chk("mt_hi", hi_w[d], cur_hi[d]);
    chk("mt_lo", lo_w[d], cur_lo[d]);
    mf_sel[d] = 2'b01; #1;
    chk("mflo_idle", rd_w[d], cur_lo[d]);
    mf_sel[d] = 2'b10; #1;
    chk("mfhi_idle", rd_w[d], cur_hi[d]);
    mf_sel[d] = 2'b00; #1;
    chk("mf_none", rd_w[d], 32'd0);
  endtask

  // k = busy cycle in which cancel is raised (0 = together with start)
  task automatic cancel_op(int d, logic [1:0] op, logic [31:0] a, logic [31:0] b, int k);
    @(negedge clk);
    start[d] = 1'b1; mul_op[d] = op; src_a[d] = a; src_b[d] = b;
    if (k == 0) cancel[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    if (k > 0) begin
      repeat (k - 1) @(negedge clk);
      chk("cancel_pre_busy", 32'(busy_w[d]), 32'd1);
      cancel[d] = 1'b1;
      @(negedge clk);
    end
    cancel[d] = 1'b0;
    chk("cancel_busy", 32'(busy_w[d]), 32'd0);
    chk("cancel_hi", hi_w[d], cur_hi[d]);
    chk("cancel_lo", lo_w[d], cur_lo[d]);
    repeat (12) @(negedge clk);
    chk("cancel_late_busy", 32'(busy_w[d]), 32'd0);
    chk("cancel_late_hi", hi_w[d], cur_hi[d]);
    chk("cancel_late_lo", lo_w[d], cur_lo[d]);
  endtask

  initial begin
    tbl[0] = '{0, 2'b01, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    tbl[1] = '{0, 2'b00, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
    tbl[2] = '{0, 2'b11, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
    tbl[3] = '{0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[4] = '{0, 2'b10, 32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF, 1'b0};
    tbl[5] = '{1, 2'b01, 32'hFFFF,     32'h2,        32'h0000FFFF, 32'h0000FFFE, 1'b0};
    tbl[6] = '{1, 2'b00, 32'hFFFF,     32'h2,        32'h00000001, 32'h0000FFFE, 1'b1};
    tbl[7] = '{1, 2'b11, 32'hFFF9,     32'h2,        32'h0000FFFF, 32'h0000FFFD, 1'b1};
    tbl[8] = '{1, 2'b11, 32'h8000,     32'hFFFF,     32'h00000000, 32'h00008000, 1'b0};
    tbl[9] = '{1, 2'b10, 32'h7,        32'h0,        32'h00000007, 32'h0000FFFF, 1'b0};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; mt_en[d] = 1'b0; mt_sel[d] = 1'b0; cancel[d] = 1'b0;
      mul_op[d] = 2'b00; mf_sel[d] = 2'b00;
      src_a[d] = '0; src_b[d] = '0; mt_data[d] = '0;
      cur_hi[d] = '0; cur_lo[d] = '0;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b1; mf_sel[d] = 2'b01;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_hi", hi_w[d], 32'd0);
      chk("rst_lo", lo_w[d], 32'd0);
      chk("rst_busy", 32'(busy_w[d]), 32'd0);
      chk("rst_stall", 32'(stall_w[d]), 32'd0);
      chk("rst_rd", rd_w[d], 32'd0);
      start[d] = 1'b0; mf_sel[d] = 2'b00;
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].d, tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, tbl[i].probe);

    mt_write(0, 1'b1, 32'h12345678);
    mt_write(1, 1'b1, 32'h00005678);
    mt_write(1, 1'b0, 32'h0000A5A5);

    cancel_op(0, 2'b00, 32'd3, 32'd4, 5);
    cancel_op(1, 2'b00, 32'd3, 32'd4, 1);
    cancel_op(0, 2'b11, 32'd100, 32'd7, 0);
    cancel_op(1, 2'b10, 32'd100, 32'd7, 0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 12; i++) begin
        logic [31:0] a, b, mask;
        logic [1:0] op;
        mask = (wid[d] == 32) ? 32'hFFFFFFFF : 32'h0000FFFF;
        op = 2'($urandom_range(0, 3));
        a = $urandom() & mask;
        b = (i % 5 == 4) ? 32'd0 : ($urandom() & mask);
        if (i % 3 == 1) b = b & 32'h1F;
        run_op(d, op, a, b, model(wid[d], op, a, b), (i % 4 == 0));
      end
    end

    // Reset pulsed between edges with both units mid-operation.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b1; mul_op[d] = 2'b11; src_a[d] = 32'd9; src_b[d] = 32'd2;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) start[d] = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_busy", 32'(busy_w[d]), 32'd0);
      chk("async_rst_hi", hi_w[d], 32'd0);
      chk("async_rst_lo", lo_w[d], 32'd0);
      cur_hi[d] = '0; cur_lo[d] = '0;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_hi", hi_w[d], 32'd0);
      chk("post_rst_lo", lo_w[d], 32'd0);
    end
    run_op(0, 2'b01, 32'hFFFFFFFD, 32'd5, model(32, 2'b01, 32'hFFFFFFFD, 32'd5), 1'b0);
    run_op(1, 2'b01, 32'h0000FFFD, 32'd5, model(16, 2'b01, 32'h0000FFFD, 32'd5), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit owning the architectural HI/LO register pair for the pipelined MIPS core. Sits in the EX stage beside the ALU. It is driven by the decoder's MulOp / MTHILO / MFHILO encodings. Width and per-operation latencies are parameters. It adds a busy/stall handshake and a flush-driven cancel.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>=2).
MUL_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  launch operation from mul_op this cycle.
mul_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
src_a  in  WIDTH  rs operand (multiplicand / dividend).
src_b  in  WIDTH  rt operand (multiplier / divisor).
mt_en  in  1  MTHI/MTLO write request.
mt_sel  in  1  0 = LO, 1 = HI.
mt_data  in  WIDTH  value for MTHI/MTLO.
mf_sel  in  2  01 MFLO, 10 MFHI, 00 none.
cancel  in  1  pipeline flush: abort in-flight operation.
busy  out  1  operation in flight.
stall  out  1  pipeline must hold the EX instruction.
rd_data  out  WIDTH  MFHI/MFLO read data.
hi  out  WIDTH  current HI.
lo  out  WIDTH  current LO.

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, counter=0, busy=0, pending result discarded. stall and rd_data then evaluate to 0.
- Idle, start=1, cancel=0 at an edge:
  - latch the full result into pending_hi/pending_lo;
  - load the counter with MUL_CYCLES (mul_op[1]=0) or DIV_CYCLES (mul_op[1]=1).
- busy = (counter != 0), registered.
- Each edge with busy=1 and cancel=0 decrements the counter. On the 1->0 decrement, HI<=pending_hi and LO<=pending_lo.
- Latency: busy is high for exactly N cycles after the accepting edge. New HI/LO are visible in the first cycle with busy=0.
- Multiply results:
  - MULTU: unsigned 2*WIDTH product.
  - MULT: signed 2*WIDTH product.
  - In both cases HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide results: LO = quotient, HI = remainder, truncating toward zero. For DIV the remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divisor 0 (DIV or DIVU): LO = all ones, HI = src_a.
  - DIV with src_a = most-negative and src_b = -1: LO = src_a, HI = 0.
- MTHI/MTLO:
  - While idle, mt_en writes HI or LO at the edge. The value is visible next cycle.
  - While busy, mt_en is ignored; stall holds the instruction until busy=0.
- start while busy: ignored and stalled. The instruction re-presents after the unit goes idle.
- stall = busy & (start | mt_en | mf_sel!=00), combinational.
- rd_data (combinational):
  - mf_sel=01 -> LO; 10 -> HI; else 0.
  - While busy, rd_data still shows the old HI/LO, but stall is asserted so the pipeline does not consume it.
- cancel=1 at an edge:
  - counter cleared, busy=0 next cycle, pending result dropped, HI/LO unchanged;
  - a simultaneous start is also dropped;
  - cancel on the final busy cycle wins: no commit.
- start with mt_en in the same idle cycle: start wins, mt_en is ignored. The decoder never issues both.
- Reset value and async reset apply to every register. No other state is kept.

Test Plan:
- MULT src_a=0xFFFFFFFF, src_b=0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Mid-op MFLO raises stall; rd_data shows the old LO.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Next, DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU src_a=7, src_b=0 -> LO=0xFFFFFFFF, HI=0x00000007. Then MTHI 0x12345678 while idle -> HI=0x12345678 next cycle, no stall.
- MULTU 3*4 started, cancel asserted in busy cycle 5 -> busy drops, HI/LO keep prior values, never 0/12.
- MULT in flight, reset pulsed asynchronously between edges -> HI=LO=0 and busy=0 immediately. Repeat the suite with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3 and check the scaled results and latencies.
